add_seq_ctrl: RTL
=================

# add_seq_ctrl

Multi-precision add/subtract sequencer that time-shares one combinational `claAdder` instance. It accepts `nwords` operand word pairs, least-significant first, over a valid/ready stream. Each pair goes through the adder with the carry registered between cycles, and each sum word is emitted on a registered output stream. It sits between a requester (host or DMA) and the adder datapath, so operands wider than `WIDTH` can be added at one word per cycle.

## Interface

Parameters
- `WIDTH`, 64, word width; passed to the internal `claAdder` instance.
- `CNT_W`, 4, width of the word count; maximum operation length is 2^CNT_W−1 words.

Ports
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  begin an operation; sampled only in IDLE.
- `nwords`  in  CNT_W  number of word pairs; captured with `start`.
- `cin`  in  1  initial carry for add mode; captured with `start`.
- `sub`  in  1  subtract mode (A−B); captured with `start`.
- `abort`  in  1  cancel the current operation.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  operand pair accepted this cycle when `in_valid` is also high.
- `a_in`  in  WIDTH  operand A word.
- `b_in`  in  WIDTH  operand B word.
- `out_valid`  out  1  sum word valid (registered).
- `out_ready`  in  1  downstream accepts the sum word.
- `s_out`  out  WIDTH  sum word (registered).
- `out_last`  out  1  high with the final sum word.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse on completion.
- `cout`  out  1  final carry-out; holds until the next completion or reset.

## Operation

- States: IDLE, RUN, DRAIN.
- IDLE:
  - `start`=1 and `nwords`≠0 → capture `nwords`, `sub`, and carry register = `sub` ? 1 : `cin`; clear the word counter; go to RUN.
  - `start` with `nwords`=0 is ignored; state stays IDLE.
- Adder inputs: A=`a_in`, B=`sub` ? ~`b_in` : `b_in`, Cin = carry register.
- RUN:
  - `in_ready` = (!`out_valid` || `out_ready`). This is combinational from `out_ready` and is permitted.
  - On an input handshake: `s_out`←S, `out_valid`←1, carry←Cout, counter+1.
  - If that handshake is word `nwords`−1, also set `out_last`←1 and go to DRAIN.
- Output stream: an output handshake with no new input clears `out_valid`. Simultaneous output and input handshakes load the new word, so `out_valid` stays 1.
- DRAIN:
  - `in_ready`=0.
  - On the output handshake of the last word: `out_valid`←0, `out_last`←0, `cout`←carry, `done`←1 for one cycle, go to IDLE.
- Subtract convention: `cout`=1 means no borrow (A≥B unsigned); `cout`=0 means borrow.
- `abort` high in RUN or DRAIN:
  - Next edge: IDLE, `out_valid`=0, `out_last`=0, `busy`=0.
  - No `done`; `cout` unchanged.
  - `abort` has priority over any handshake in the same cycle and is ignored in IDLE.
- `start` while not IDLE is ignored.
- Arithmetic is modulo 2^WIDTH per word. The carry is the only state that crosses words.

## Timing

- Reset values: `in_ready`=0, `out_valid`=0, `s_out`=0, `out_last`=0, `busy`=0, `done`=0, `cout`=0; state IDLE; carry and counter 0.
- Reset asserted mid-operation discards everything immediately (asynchronous).
- `start` sampled at edge t → `busy`=1 and `in_ready` can be 1 from t+1.
- Latency is one cycle: a pair accepted at edge k gives `s_out` valid after edge k.
- Throughput is one word per cycle when `out_ready` is held high.
- An n-word operation with no backpressure:
  - first input at edge t+1;
  - last output handshake at t+n+1;
  - `done`/`cout` valid after t+n+1;
  - `busy`=0 after t+n+1;
  - the next `start` is accepted at t+n+2.
- `s_out` and `out_last` hold stable while `out_valid`=1 and `out_ready`=0.

## Test plan

- Single-word add (`WIDTH`=64): `nwords`=1, A=5, B=5, `cin`=0 → `s_out`=10, `out_last`=1, `done` pulse, `cout`=0. Then A=B=7, `cin`=1 → 15.
- Carry chain across two words: `nwords`=2, A={lo: all-ones, hi: 0}, B={lo: 1, hi: 0} → words 0 then 1, `cout`=0. Repeat with A and B all-ones in all 15 words (`nwords`=15), `cin`=1 → every word all-ones, `cout`=1.
- Subtract:
  - A=5, B=3 → 2, `cout`=1.
  - A=3, B=5 → 0xFFFF_FFFF_FFFF_FFFE, `cout`=0.
  - `cin` is ignored in subtract mode.
- Backpressure, 4-word add:
  - hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0, `s_out` stable.
  - Then stream with `out_ready` toggling → all 4 words correct, no loss or duplication.
- Abort and reset:
  - `abort` after 2 of 4 words → `busy`=0 and `out_valid`=0 next cycle, no `done`, `cout` unchanged; the next `start` completes correctly.
  - `rst_n` low mid-RUN → all outputs at reset values immediately.
- Ignored starts: `start` with `nwords`=0 → `busy` stays 0. `start` pulsed during RUN → no effect on the sequence or the result.

Source files
------------

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: multi-precision add/subtract sequencer.
//
// Streams nwords operand pairs (least-significant word first) through a single
// combinational claAdder. The carry is registered between words, so operands
// wider than WIDTH are added at one word per cycle.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, nwords       begin an operation of nwords pairs (taken in IDLE only)
//   cin, sub            initial carry (add mode), subtract mode (A-B)
//   abort               cancel the operation in progress
//   in_valid/in_ready   operand stream handshake; a_in, b_in operand words
//   out_valid/out_ready result stream handshake; s_out sum word, out_last final word
//   busy                operation in progress
//   done                one-cycle completion pulse
//   cout                final carry (1 = no borrow in subtract mode)

// claAdder: combinational adder, lookahead inside 4-bit groups with the
// group carries chained from group to group.
module claAdder #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    logic term;
    logic prod;
    logic cprev;
    logic cgrp;
    // NOTE: every combinational output gets a value before any loop or branch,
    // so no path leaves it unassigned and no latch is inferred.
    s     = '0;
    term  = 1'b0;
    prod  = 1'b0;
    cprev = cin;
    cgrp  = cin;
    for (int base = 0; base < WIDTH; base += 4) begin
      cprev = cgrp;
      for (int j = base; j < base + 4 && j < WIDTH; j++) begin
        s[j] = p[j] ^ cprev;
        // Carry out of bit j expanded as a sum of products back to the group carry-in.
        term = g[j];
        prod = p[j];
        for (int m = j - 1; m >= base; m--) begin
          term = term | (prod & g[m]);
          prod = prod & p[m];
        end
        cprev = term | (prod & cgrp);
      end
      cgrp = cprev;
    end
    cout = cgrp;
  end
endmodule

module add_seq_ctrl #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] nwords,
  input  logic             cin,
  input  logic             sub,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s_out,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             cout
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nwords_q;
  logic             sub_q;
  logic             carry;

  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_s;
  logic             add_cout;
  logic             in_hs;
  logic             out_hs;

  // Subtraction is A + ~B + 1; the +1 comes from the carry preset at start.
  assign add_b = sub_q ? ~b_in : b_in;

  claAdder #(.WIDTH(WIDTH)) u_add (
    .a    (a_in),
    .b    (add_b),
    .cin  (carry),
    .s    (add_s),
    .cout (add_cout)
  );

  // Accept a new pair whenever the output register is empty or draining this cycle.
  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign busy     = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      nwords_q  <= '0;
      sub_q     <= 1'b0;
      carry     <= 1'b0;
      s_out     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      cout      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (nwords != '0)) begin
            nwords_q <= nwords;
            sub_q    <= sub;
            carry    <= sub ? 1'b1 : cin;
            cnt      <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state     <= IDLE;
          end else if (in_hs) begin
            // A simultaneous output handshake is covered: the register reloads.
            s_out     <= add_s;
            out_valid <= 1'b1;
            carry     <= add_cout;
            cnt       <= cnt + CNT_ONE;
            if (cnt == nwords_q - CNT_ONE) begin
              out_last <= 1'b1;
              state    <= DRAIN;
            end
          end else if (out_hs) begin
            out_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (abort) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state     <= IDLE;
          end else if (out_hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            cout      <= carry;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
